// File: rtl/md_ctrl.sv
// Multiply/divide sequencer and HI/LO register owner.
// An accepted mult/div computes its result at once and parks it in a
// pending register. A fixed-length busy countdown then runs, and the
// result is committed to HI/LO on the final busy edge.
module md_ctrl #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] ins_D,
    input  logic [31:0] ins_E,
    input  logic [31:0] RData1_E,
    input  logic [31:0] RData2_E,
    output logic [31:0] HiLo_E,
    output logic        Start,
    output logic        Busy,
    output logic        Stall_MD,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CntW      = $clog2(MaxCycles + 1);

    localparam logic [5:0] FnMfhi  = 6'b010000;
    localparam logic [5:0] FnMthi  = 6'b010001;
    localparam logic [5:0] FnMflo  = 6'b010010;
    localparam logic [5:0] FnMtlo  = 6'b010011;
    localparam logic [5:0] FnMult  = 6'b011000;
    localparam logic [5:0] FnMultu = 6'b011001;
    localparam logic [5:0] FnDiv   = 6'b011010;
    localparam logic [5:0] FnDivu  = 6'b011011;

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [63:0]       pend_q, pend_d;
    logic              pend_wr_q, pend_wr_d;
    logic [31:0]       hi_q, hi_d;
    logic [31:0]       lo_q, lo_d;

    // R-type decode helpers
    function automatic logic is_fn(input logic [31:0] ins, input logic [5:0] fn);
        return (ins[31:26] == 6'b000000) && (ins[5:0] == fn);
    endfunction

    function automatic logic is_md_op(input logic [31:0] ins);
        return is_fn(ins, FnMult) | is_fn(ins, FnMultu) | is_fn(ins, FnDiv) | is_fn(ins, FnDivu);
    endfunction

    function automatic logic is_hilo(input logic [31:0] ins);
        return is_md_op(ins) | is_fn(ins, FnMfhi) | is_fn(ins, FnMflo)
             | is_fn(ins, FnMthi) | is_fn(ins, FnMtlo);
    endfunction

    logic [31:0] a, b;
    assign a = RData1_E;
    assign b = RData2_E;

    // Products: sign-extend to 64 bits so the low 64 bits are the exact product
    logic [63:0] prod_s, prod_u;
    assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    assign prod_u = {32'd0, a} * {32'd0, b};

    // Signed divide done on magnitudes so 0x80000000 / -1 needs no special case
    logic [31:0] a_mag, b_mag, den_s, den_u;
    logic [31:0] q_mag, r_mag, q_s, r_s, q_u, r_u;
    assign a_mag = a[31] ? (32'd0 - a) : a;
    assign b_mag = b[31] ? (32'd0 - b) : b;
    // A zero divisor is replaced by 1; that result is never committed
    assign den_s = (b_mag == 32'd0) ? 32'd1 : b_mag;
    assign den_u = (b == 32'd0) ? 32'd1 : b;
    assign q_mag = a_mag / den_s;
    assign r_mag = a_mag % den_s;
    assign q_s   = (a[31] ^ b[31]) ? (32'd0 - q_mag) : q_mag;
    assign r_s   = a[31] ? (32'd0 - r_mag) : r_mag;
    assign q_u   = a / den_u;
    assign r_u   = a % den_u;

    logic        e_is_div;
    logic [63:0] result;
    assign e_is_div = is_fn(ins_E, FnDiv) | is_fn(ins_E, FnDivu);

    // Select the {HI,LO} result for the E-stage operation
    always_comb begin
        result = prod_u;
        if (is_fn(ins_E, FnMult)) begin
            result = prod_s;
        end else if (is_fn(ins_E, FnDiv)) begin
            result = {r_s, q_s};
        end else if (is_fn(ins_E, FnDivu)) begin
            result = {r_u, q_u};
        end
    end

    assign Start    = is_md_op(ins_E) && (state_q == StIdle);
    assign Busy     = (state_q == StRun);
    assign Stall_MD = (Busy | Start) & is_hilo(ins_D);
    assign HI       = hi_q;
    assign LO       = lo_q;

    // mfhi/mflo read the architectural registers directly
    always_comb begin
        HiLo_E = 32'd0;
        if (is_fn(ins_E, FnMfhi)) begin
            HiLo_E = hi_q;
        end else if (is_fn(ins_E, FnMflo)) begin
            HiLo_E = lo_q;
        end
    end

    // Next-state: launch, countdown, commit, and mthi/mtlo writes while idle
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pend_d    = pend_q;
        pend_wr_d = pend_wr_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        unique case (state_q)
            StIdle: begin
                if (Start) begin
                    state_d   = StRun;
                    cnt_d     = e_is_div ? CntW'(DIV_CYCLES) : CntW'(MULT_CYCLES);
                    pend_d    = result;
                    pend_wr_d = !(e_is_div && (b == 32'd0));
                end else if (is_fn(ins_E, FnMthi)) begin
                    hi_d = a;
                end else if (is_fn(ins_E, FnMtlo)) begin
                    lo_d = a;
                end
            end
            StRun: begin
                cnt_d = cnt_q - CntW'(1);
                if (cnt_q == CntW'(1)) begin
                    state_d = StIdle;
                    if (pend_wr_q) begin
                        hi_d = pend_q[63:32];
                        lo_d = pend_q[31:0];
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            pend_q    <= '0;
            pend_wr_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pend_q    <= pend_d;
            pend_wr_q <= pend_wr_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    // Register-number and shamt fields are not used by this unit
    logic unused_fields;
    assign unused_fields = ^{ins_D[25:6], ins_E[25:6]};

endmodule

// File: doc/md_ctrl.md
Name: md_ctrl

Overview:
- Multiply/divide sequencer and HI/LO owner for the 5-stage MIPS pipeline.
- Accepts mult/multu/div/divu from the E stage using forwarded operands.
- Runs a fixed-latency busy countdown and commits results to HI/LO when it completes.
- Serves mfhi/mflo/mthi/mtlo, and raises a D-stage stall for any HI/LO-class instruction while the unit is occupied.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (>=1)
- DIV_CYCLES, 10, busy cycles for div/divu (>=1)

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- ins_D  input  32  instruction in D stage
- ins_E  input  32  instruction in E stage
- RData1_E  input  32  forwarded rs operand in E
- RData2_E  input  32  forwarded rt operand in E
- HiLo_E  output  32  HI for mfhi in E, LO for mflo in E, else 0
- Start  output  1  ins_E is mult/multu/div/divu and state is IDLE
- Busy  output  1  registered; high while an operation is counting down
- Stall_MD  output  1  D-stage stall request
- HI  output  32  HI register
- LO  output  32  LO register

Behaviour:
- Instruction decode (opcode 000000 only):
  - funct 011000 mult, 011001 multu, 011010 div, 011011 divu
  - funct 010000 mfhi, 010010 mflo, 010001 mthi, 010011 mtlo
  - Any other opcode or funct is not HI/LO-class.
- Reset:
  - State goes to IDLE; Busy=0, counter=0.
  - HI=0, LO=0, and the pending result register is cleared.
  - Reset has priority over everything, including mid-operation; an in-flight result is discarded.
- States:
  - IDLE to RUN on Start. At that edge:
    - latch the 64-bit result into the pending register;
    - load counter with MULT_CYCLES or DIV_CYCLES;
    - set Busy=1.
  - In RUN, the counter decrements every cycle.
  - When counter==1, at that edge: commit pending result to HI/LO, set Busy=0, return to IDLE.
- Latency:
  - Start sampled at edge t gives Busy high for exactly N cycles (N = MULT_CYCLES or DIV_CYCLES).
  - New HI/LO values are visible in the cycle Busy first reads 0.
- Arithmetic:
  - mult: {HI,LO} = signed 32x32 to 64-bit product.
  - multu: {HI,LO} = unsigned 32x32 to 64-bit product.
  - div: LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - divu: LO = unsigned quotient; HI = unsigned remainder.
  - div of 0x80000000 by 0xFFFFFFFF: LO=0x80000000, HI=0.
  - Divide by zero (div or divu): full DIV_CYCLES busy period runs, HI and LO stay unchanged.
- mthi/mtlo:
  - When ins_E is mthi/mtlo and state is IDLE, HI (resp. LO) = RData1_E at the next edge.
  - If the same edge also completes an operation, the commit wins; this cannot occur when stalling is honoured.
- mfhi/mflo:
  - HiLo_E is combinational from the current HI/LO registers.
  - Before the commit edge, it shows the old values.
- Stall_MD:
  - Combinational: (Busy | Start) & (ins_D is HI/LO-class).
  - Non-HI/LO instructions never stall.
- Conflicting E-stage instruction:
  - A HI/LO-class ins_E while Busy is a protocol violation and is ignored: no restart, no mthi/mtlo write.
  - Start is forced 0 while Busy.
- Back-to-back operations: a new Start is accepted in the first cycle Busy is 0 after the commit.

Test Plan:
- Reset then idle -> HI=0, LO=0, Busy=0, Stall_MD=0, HiLo_E=0; assert reset for 2 cycles mid-RUN -> Busy=0 next cycle, HI/LO=0.
- mult with RData1_E=0xFFFFFFFE (-2), RData2_E=3 -> Busy high exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA; multu on the same operands -> HI=0x00000002, LO=0xFFFFFFFA.
- div -7/2 -> after 10 busy cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu 7/0 -> 10 busy cycles, HI/LO unchanged.
- mult in E with mflo in D -> Stall_MD=1 in the Start cycle and all 5 Busy cycles, 0 the cycle Busy falls; mflo then sees HiLo_E = new LO.
- addu in D while Busy -> Stall_MD=0; mthi in E with RData1_E=0x12345678 while IDLE -> HI=0x12345678 next cycle, and a following mfhi gives HiLo_E=0x12345678.
- div 0x80000000 by 0xFFFFFFFF -> LO=0x80000000, HI=0; immediately followed by multu -> Start accepted in the first cycle Busy=0.
